// File: rtl/print_output_unit.sv
`default_nettype none
// ============================================================================
// Module   : print_output_unit
// Brief    : Buffers datapath print values in a FIFO and shows each one as
//            decimal BCD using an iterative double-dabble converter.
//            Optional macro PRINT_SIGNED_EN: values are two's-complement.
// Revision : 1.0 - initial release
// ============================================================================
module print_output_unit #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   print,
    input  logic                   pause,
    input  logic [31:0]            ALU_result,
    output logic [39:0]            digits,
    output logic                   negative,
    output logic                   display_valid,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   overflow
);
    localparam int              c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL      = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE   = (c_AW)'(1);
    localparam logic [31:0]     c_HOLD_LAST = 32'(HOLD_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CONVERT = 2'd1;
    localparam logic [1:0] c_ST_SHOW    = 2'd2;

    logic [31:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic [1:0]      r_state;
    logic [71:0]     r_shift;
    logic [4:0]      r_iter;
    logic [31:0]     r_hold;
    logic [39:0]     r_digits;
    logic            r_display_valid;

    logic        w_push_req;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_conv_done;
    logic [31:0] w_head;
    logic [31:0] w_mag;
    logic [71:0] w_adj;
    logic [71:0] w_next;

    assign w_push_req  = print && !pause;
    assign w_full      = (r_count == c_FULL);
    assign w_pop       = (r_state == c_ST_IDLE) && (r_count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_conv_done = (r_state == c_ST_CONVERT) && (r_iter == 5'd31);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - c_CNT_ONE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wr_ptr] <= ALU_result;
    end

    // Add-3 correction on every BCD nibble, then shift the whole register.
    for (genvar gi = 0; gi < 10; gi++) begin : g_nibble
        logic [3:0] w_nib;
        assign w_nib = r_shift[32 + 4*gi +: 4];
        assign w_adj[32 + 4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end
    assign w_adj[31:0] = r_shift[31:0];
    assign w_next      = w_adj << 1;

`ifdef PRINT_SIGNED_EN
    logic r_sign;
    logic r_negative;

    assign w_mag = w_head[31] ? (~w_head + 32'd1) : w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign     <= 1'b0;
            r_negative <= 1'b0;
        end else begin
            if (w_pop)       r_sign     <= w_head[31];
            if (w_conv_done) r_negative <= r_sign;
        end
    end

    assign negative = r_negative;
`else
    assign w_mag    = w_head;
    assign negative = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_shift         <= '0;
            r_iter          <= '0;
            r_hold          <= '0;
            r_digits        <= '0;
            r_display_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= {40'd0, w_mag};
                        r_iter  <= '0;
                        r_state <= c_ST_CONVERT;
                    end
                end
                c_ST_CONVERT: begin
                    r_shift <= w_next;
                    r_iter  <= r_iter + 5'd1;
                    if (w_conv_done) begin
                        r_digits        <= w_next[71:32];
                        r_display_valid <= 1'b1;
                        r_hold          <= '0;
                        r_state         <= c_ST_SHOW;
                    end
                end
                c_ST_SHOW: begin
                    if (r_hold == c_HOLD_LAST) r_state <= c_ST_IDLE;
                    else                       r_hold  <= r_hold + 32'd1;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign digits        = r_digits;
    assign display_valid = r_display_valid;
    assign busy          = (r_state != c_ST_IDLE);
    assign pending       = r_count;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: doc/print_output_unit.md
# print_output_unit

Downstream consumer of the single-cycle MIPS datapath's `print` strobe and `ALU_result` bus. It captures every printed value into a small FIFO, so back-to-back print instructions are never lost. It converts each value, one at a time, to decimal BCD with an iterative shift-add-3 (double-dabble) engine. Each result is held on the display outputs for a programmable number of cycles before the next value is shown.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `HOLD_CYCLES`, 4: cycles each converted value is held before the next pop; ≥1; 32-bit counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high; clears all state on the rising edge of `clk`.
- `print`  in  1  print strobe from the datapath control unit.
- `pause`  in  1  datapath pause; while high, no capture occurs.
- `ALU_result`  in  32  value to print.
- `digits`  out  40  ten BCD digits; [3:0] is least significant.
- `negative`  out  1  displayed value is negative.
- `display_valid`  out  1  `digits` holds a converted value.
- `busy`  out  1  converter not in IDLE.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: a capture was dropped.

## Operation
Reset values:
- `digits` = 0, `negative` = 0, `display_valid` = 0, `busy` = 0, `pending` = 0, `overflow` = 0.
- FSM in IDLE; FIFO pointers and all counters at 0.

Capture:
- Condition: `print && !pause` at a rising edge.
- Each unpaused cycle is one instruction, so consecutive print instructions capture one value each.
- Push writes `ALU_result` at the tail.

FIFO boundaries:
- Push and pop in the same cycle: both take effect; `pending` is unchanged. This holds when full.
- Push when full with no pop: the value is dropped, `overflow` is set, and it stays set until `reset`.
- Pop is issued only by the FSM in IDLE when `pending` > 0, so pop on empty cannot occur.
- Pointers wrap modulo `DEPTH`.

FSM:
- IDLE: if `pending` > 0, pop the head into a 72-bit shift register.
  - Upper 40 bits = 0; lower 32 bits = magnitude.
  - Latch the sign; clear the iteration counter; go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT: one double-dabble iteration per cycle.
  - Each BCD nibble ≥5 gets +3, then the whole register shifts left 1.
  - After the 32nd iteration, in the same edge: register `digits` from the upper 40 bits, register `negative` from the latched sign, set `display_valid` = 1, clear the hold counter, go to SHOW.
- SHOW: increment the hold counter. When it reaches `HOLD_CYCLES` − 1, go to IDLE.
- `digits`, `negative` and `display_valid` keep their values until the next conversion completes, or until reset.
- `busy` = (state ≠ IDLE).

## Timing
Capture to display:
- Capture at edge E0 (FIFO initially empty and FSM idle).
- Pop at E1.
- Iterations at E2 through E33.
- `digits` valid after E33: latency 33 cycles.

Per-value period:
- 1 (pop) + 32 (convert) + `HOLD_CYCLES` cycles.
- With the default parameters, the next pop occurs at E38.

Back-to-back captures:
- Captures at E0..E9 with the converter busy: pop at E1, so occupancy reaches 8 at E8.
- The 10th capture (E9) is dropped.

Reset mid-operation:
- Reset during CONVERT or SHOW aborts the current value, empties the FIFO, and returns all outputs to their reset values on that edge.
- A `print` in the reset cycle is not captured.

## Configuration
Macro: `PRINT_SIGNED_EN`.
- Defined: values are two's-complement.
  - Magnitude = −value when bit 31 = 1; `negative` = bit 31.
  - −2147483648 is displayed as magnitude 2147483648 with `negative` = 1.
- Undefined: values are unsigned and `negative` is tied to 0. The sign-latch logic is not compiled.

## Test plan
- Reset check: hold `reset` 2 cycles, then release → all outputs 0, `pending` = 0, `busy` = 0.
- Basic value: `ALU_result` = 123, `print` = 1 for 1 cycle with `pause` = 0 → 33 cycles later `digits` = 40'h0000000123, `negative` = 0, `display_valid` = 1.
- Negative input, `ALU_result` = 32'hFFFFFFFF:
  - With `PRINT_SIGNED_EN`: `digits` = 40'h0000000001, `negative` = 1.
  - Without it: `digits` = 40'h4294967295, `negative` = 0.
- Overflow:
  - Stimulus: `print` held 10 consecutive cycles with values 1..10 and `pause` = 0.
  - Response: `overflow` = 1 after the 10th edge and `pending` = 8.
  - Displayed sequence is 1..9 (value 10 is never shown), each held `HOLD_CYCLES`.
- Pause gating: `print` = 1 with `pause` = 1 for 5 cycles → `pending` stays 0 and no conversion occurs. Dropping `pause` for 1 cycle → exactly 1 capture.
- Reset mid-conversion: assert `reset` 10 cycles into CONVERT → after that edge, state is IDLE, `pending` = 0, and `digits` = 0 with no later update.
